// File: rtl/sub64_serial.sv
// Multi-cycle borrow-chained subtractor. One SLICE-wide subtract stage is
// reused LSB-first for WIDTH/SLICE cycles behind a valid/ready handshake.
module sub64_serial #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned SLICE = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned NS = WIDTH / SLICE;
  localparam int unsigned KW = (NS > 1) ? $clog2(NS) : 1;

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  res_q, res_d;
  logic              borrow_q, borrow_d;
  logic [KW-1:0]     k_q, k_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic [WIDTH:0]    out_q, out_d;
  logic              ovf_q, ovf_d;
  logic              zero_q, zero_d;

  logic [31:0]       lo;
  logic [SLICE-1:0]  a_s, b_s, d_s;
  logic              b_out;
  logic [WIDTH-1:0]  res_full;

  // Current slice of each operand and the single shared subtract stage.
  always_comb begin
    lo       = SLICE * 32'(k_q);
    a_s      = a_q[lo +: SLICE];
    b_s      = b_q[lo +: SLICE];
    {b_out, d_s} = {1'b0, a_s} - {1'b0, b_s} - {{SLICE{1'b0}}, borrow_q};
    res_full = res_q;
    res_full[lo +: SLICE] = d_s;
  end

  // Next-state and datapath control.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    res_d       = res_q;
    borrow_d    = borrow_q;
    k_d         = k_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_d       = out_q;
    ovf_d       = ovf_q;
    zero_d      = zero_q;
    unique case (state_q)
      StIdle: begin
        if (!in_ready_q) begin
          // First edge after reset release opens the input.
          in_ready_d = 1'b1;
        end else if (in_valid) begin
          a_d        = in1;
          b_d        = in2;
          borrow_d   = bin;
          k_d        = '0;
          in_ready_d = 1'b0;
          state_d    = StCalc;
        end
      end
      StCalc: begin
        res_d    = res_full;
        borrow_d = b_out;
        if (k_q == KW'(NS - 1)) begin
          k_d         = '0;
          out_valid_d = 1'b1;
          out_d       = {b_out, res_full};
          ovf_d       = (a_q[WIDTH-1] != b_q[WIDTH-1]) & (res_full[WIDTH-1] != a_q[WIDTH-1]);
          zero_d      = (res_full == '0);
          state_d     = StDone;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      StDone: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State register with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      borrow_q    <= 1'b0;
      k_q         <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      res_q       <= res_d;
      borrow_q    <= borrow_d;
      k_q         <= k_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_sub64_serial.sv
// Scoreboard bench for sub64_serial: expected results are queued at issue and
// compared by a monitor on each output handshake.
module tb_sub64_serial;

  localparam int unsigned W = 64;

  typedef struct packed {
    logic [W:0] o;
    logic       ov;
    logic       z;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in1 = '0;
  logic [W-1:0] in2 = '0;
  logic         bin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W:0]   out;
  logic         ovf;
  logic         zero;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb[$];

  sub64_serial #(.WIDTH(64), .SLICE(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in1       (in1),
    .in2       (in2),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .ovf       (ovf),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W:0] got, input logic [W:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
    exp_t e;
    e.o  = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bi};
    e.ov = (a[W-1] != b[W-1]) & (e.o[W-1] != a[W-1]);
    e.z  = (e.o[W-1:0] == '0);
    return e;
  endfunction

  // Monitor: compare each result as it is handed off.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_result", 1'b1, 1'b0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("out", out, e.o);
        check("ovf", {64'd0, ovf}, {64'd0, e.ov});
        check("zero", {64'd0, zero}, {64'd0, e.z});
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) check("ready_timeout", 1'b0, 1'b1);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!out_valid) check("valid_timeout", 1'b0, 1'b1);
  endtask

  // Single operation with out_ready=1, checking exact latency and turnaround.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi,
                        input exp_t e);
    wait_ready();
    in1 = a; in2 = b; bin = bi; in_valid = 1'b1;
    sb.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in1 = ~a; in2 = ~b; bin = ~bi;  // must not disturb latched operands
    check("acc_in_ready", {64'd0, in_ready}, 65'd0);
    check("early_valid0", {64'd0, out_valid}, 65'd0);
    @(posedge clk); #1;
    check("early_valid1", {64'd0, out_valid}, 65'd0);
    @(posedge clk); #1;
    check("latency_valid", {64'd0, out_valid}, 65'd1);
    @(posedge clk); #1;
    check("hs_valid_low", {64'd0, out_valid}, 65'd0);
    check("hs_in_ready", {64'd0, in_ready}, 65'd1);
  endtask

  initial begin
    exp_t e;
    logic [W:0] snap_o;
    logic snap_ov, snap_z;
    logic [W-1:0] ra, rb;
    logic rbi;

    // Reset values.
    #2;
    check("rst_in_ready", {64'd0, in_ready}, 65'd0);
    check("rst_out_valid", {64'd0, out_valid}, 65'd0);
    check("rst_out", out, 65'd0);
    check("rst_flags", {63'd0, ovf, zero}, 65'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("ready_after_rst", {64'd0, in_ready}, 65'd1);

    // Directed cases.
    e = '{o: {1'b0, 64'h0F}, ov: 1'b0, z: 1'b0};
    run_op(64'h10, 64'h01, 1'b0, e);
    e = '{o: {1'b0, 64'h0000_0000_FFFF_FFFF}, ov: 1'b0, z: 1'b0};
    run_op(64'h0000_0001_0000_0000, 64'd1, 1'b0, e);
    e = '{o: {1'b1, 64'hFFFF_FFFF_FFFF_FFFF}, ov: 1'b0, z: 1'b0};
    run_op(64'd0, 64'd1, 1'b0, e);
    e = '{o: 65'd0, ov: 1'b0, z: 1'b1};
    run_op(64'd5, 64'd4, 1'b1, e);
    e = '{o: {1'b0, 64'h7FFF_FFFF_FFFF_FFFF}, ov: 1'b1, z: 1'b0};
    run_op(64'h8000_0000_0000_0000, 64'd1, 1'b0, e);
    e = '{o: {1'b1, 64'h8000_0000_0000_0000}, ov: 1'b1, z: 1'b0};
    run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, e);

    // Random cases against the arithmetic model.
    for (int i = 0; i < 10; i++) begin
      ra  = {$urandom, $urandom};
      rb  = {$urandom, $urandom};
      rbi = 1'($urandom_range(0, 1));
      if (i == 0) rb = ra;
      run_op(ra, rb, rbi, model(ra, rb, rbi));
    end

    // Backpressure with in_valid held high across two operations.
    out_ready = 1'b0;
    wait_ready();
    in1 = 64'h1234_5678_9ABC_DEF0; in2 = 64'h0FED_CBA9_8765_4321; bin = 1'b1;
    in_valid = 1'b1;
    sb.push_back(model(in1, in2, bin));
    @(posedge clk); #1;
    in1 = 64'd100; in2 = 64'd58; bin = 1'b0;
    sb.push_back('{o: {1'b0, 64'd42}, ov: 1'b0, z: 1'b0});
    wait_valid();
    snap_o = out; snap_ov = ovf; snap_z = zero;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_out", out, snap_o);
      check("bp_flags", {63'd0, ovf, zero}, {63'd0, snap_ov, snap_z});
      check("bp_in_ready", {64'd0, in_ready}, 65'd0);
      check("bp_valid", {64'd0, out_valid}, 65'd1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_rel_ready", {64'd0, in_ready}, 65'd1);
    check("bp_rel_valid", {64'd0, out_valid}, 65'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_second_acc", {64'd0, in_ready}, 65'd0);
    wait_valid();
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("bp_no_extra", {64'd0, out_valid}, 65'd0);
    end
    check("bp_drained", 65'(sb.size()), 65'd0);

    // Reset during CALC: operation A is dropped, B then completes normally.
    wait_ready();
    in1 = 64'hDEAD_BEEF_0000_0000; in2 = 64'd1; bin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #3;
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", {64'd0, in_ready}, 65'd0);
    check("mid_rst_valid", {64'd0, out_valid}, 65'd0);
    check("mid_rst_out", out, 65'd0);
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("no_result_A", {64'd0, out_valid}, 65'd0);
    end
    e = '{o: {1'b0, 64'd4}, ov: 1'b0, z: 1'b0};
    run_op(64'd7, 64'd3, 1'b0, e);

    repeat (3) @(posedge clk);
    check("final_drain", 65'(sb.size()), 65'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
